// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencing FSM for the single-issue RV32I core.
// Optional retire counter: define FETCH_SEQ_RETIRE_CNT_EN.
module fetch_sequencer #(
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned DATA_W      = 32
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic              halt_req,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              exec_done,
   input  logic              is_jump,
   input  logic              branch_taken,
   input  logic              stall,
   output logic              imem_req,
   output logic [DATA_W-1:0] instr,
   output logic              pc_inc,
   output logic              pc_load,
   output logic              pc_branch,
   output logic              pc_disable,
   output logic              busy,
   output logic              fault,
   output logic [31:0]       retired
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_ADV,
      S_FAULT
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [7:0]        wait_q, wait_d;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_IDLE;
         instr_q <= '0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         instr_q <= instr_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      wait_d     = wait_q;
      imem_req   = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      pc_branch  = 1'b0;
      pc_disable = 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               wait_d  = '0;
            end
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               wait_d  = '0;
               state_d = S_EXEC;
            end else if (wait_q == 8'(TIMEOUT_CYC - 1)) begin
               state_d = S_FAULT;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_EXEC: begin
            if (exec_done) state_d = S_ADV;
         end
         S_ADV: begin
            // a stalled ADVANCE holds the PC and ignores halt_req
            if (!stall) begin
               pc_disable = 1'b0;
               if (is_jump)           pc_load   = 1'b1;
               else if (branch_taken) pc_branch = 1'b1;
               else                   pc_inc    = 1'b1;
               state_d = halt_req ? S_IDLE : S_FETCH;
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign instr = instr_q;
   assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                  (state_q == S_ADV);
   assign fault = (state_q == S_FAULT);

`ifdef FETCH_SEQ_RETIRE_CNT_EN
   logic [31:0] ret_q;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         ret_q <= '0;
      else if (pc_inc || pc_load || pc_branch)
         ret_q <= ret_q + 32'd1;
   end

   assign retired = ret_q;
`else
   assign retired = '0;
`endif

endmodule
